// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one registered ALU among N_REQ requesters.
// Stays locked until START_CODE is seen, then issues one op at a time and returns tagged results.
module alu_share_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OP_W       = 3,
    parameter int unsigned ALU_LAT    = 1,
    parameter logic [31:0] START_CODE = 32'hAF95FE47,
    localparam int unsigned ID_W      = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              start_value,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*OP_W-1:0]    req_op,
    input  logic [N_REQ*DATA_W-1:0]  req_a,
    input  logic [N_REQ*DATA_W-1:0]  req_b,
    output logic [N_REQ-1:0]         gnt,
    output logic [OP_W-1:0]          alu_opcode,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    input  logic [DATA_W-1:0]        alu_result,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic                     enabled,
    output logic                     busy
);

    localparam int unsigned CNT_W  = $clog2(ALU_LAT) + 1;
    localparam logic [OP_W-1:0] MAX_OP = OP_W'(4);

    typedef enum logic [1:0] {StLocked, StIdle, StIssue, StWait} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                err_q, err_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                enabled_q, enabled_d;

    logic [OP_W-1:0]     op_arr [N_REQ];
    logic [DATA_W-1:0]   a_arr  [N_REQ];
    logic [DATA_W-1:0]   b_arr  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[g*OP_W +: OP_W];
        assign a_arr[g]  = req_a[g*DATA_W +: DATA_W];
        assign b_arr[g]  = req_b[g*DATA_W +: DATA_W];
    end

    // Scan starts one past the last winner, so the previous winner has lowest priority.
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(last_q) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        err_d       = err_q;
        gnt_d       = '0;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        enabled_d   = enabled_q;
        case (state_q)
            StLocked: begin
                if (start_value == START_CODE) begin
                    enabled_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StIdle: begin
                if (found) begin
                    last_d     = win;
                    id_d       = win;
                    err_d      = op_arr[win] > MAX_OP;
                    alu_op_d   = (op_arr[win] > MAX_OP) ? '0 : op_arr[win];
                    alu_a_d    = a_arr[win];
                    alu_b_d    = b_arr[win];
                    gnt_d[win] = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = CNT_W'(ALU_LAT - 1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = err_q ? '0 : alu_result;
                    rsp_id_d    = id_q;
                    rsp_err_d   = err_q;
                    rsp_valid_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StLocked;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StLocked;
            last_q      <= ID_W'(N_REQ - 1);
            cnt_q       <= '0;
            id_q        <= '0;
            err_q       <= 1'b0;
            gnt_q       <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            enabled_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            err_q       <= err_d;
            gnt_q       <= gnt_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            enabled_q   <= enabled_d;
        end
    end

    assign gnt        = gnt_q;
    assign alu_opcode = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign enabled    = enabled_q;
    assign busy       = (state_q == StIssue) || (state_q == StWait);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a timing-level reference model predicts grants and
// responses at each edge; a negedge monitor pops and compares them against the DUT.
module tb_alu_share_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int OW  = 3;
    localparam int LAT = 1;
    localparam logic [31:0] CODE = 32'hAF95FE47;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     start_value;
    logic [N-1:0]    req;
    logic [N*OW-1:0] req_op;
    logic [N*DW-1:0] req_a, req_b;
    logic [N-1:0]    gnt;
    logic [OW-1:0]   alu_opcode;
    logic [DW-1:0]   alu_a, alu_b, alu_result;
    logic            rsp_valid, rsp_err, enabled, busy;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .N_REQ(N), .DATA_W(DW), .OP_W(OW), .ALU_LAT(LAT), .START_CODE(CODE)
    ) dut (
        .clk(clk), .rst(rst), .start_value(start_value), .req(req), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .gnt(gnt), .alu_opcode(alu_opcode), .alu_a(alu_a),
        .alu_b(alu_b), .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .enabled(enabled), .busy(busy)
    );

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ~a;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) alu_result <= alu_f(alu_opcode, alu_a, alu_b);

    typedef struct { int edge_no; int id; logic [2:0] op; logic [7:0] a; logic [7:0] b; } gnt_t;
    typedef struct { int edge_no; int id; logic [7:0] data; logic err; } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    int   gnt_log[$];
    int   gnt_edge_log[$];
    int   vectors = 0, miscompares = 0;
    int   edge_n = 0, g_edge = -100, next_ok = 0, last = N - 1;
    bit   locked = 1'b1;
    int   n_rsp = 0, last_id = 0;
    logic [7:0] last_data;
    logic last_err;
    bit   auto_en = 1'b0, rr_mode = 1'b0;
    logic [N-1:0] rearm = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp_v, edge_n);
        end
    endtask

    // Reference model: a grant may start once the previous op's slot (LAT+2 edges) has elapsed.
    initial begin
        int w;
        int idx;
        logic [2:0] op;
        logic [7:0] a, b;
        logic err;
        forever begin
            @(posedge clk);
            edge_n++;
            if (!rst) begin
                locked = 1'b1;
                last   = N - 1;
                g_edge = -100;
                gq.delete();
                rq.delete();
            end else if (locked) begin
                if (start_value == CODE) begin
                    locked  = 1'b0;
                    next_ok = edge_n + 1;
                end
            end else if (edge_n >= next_ok && req != '0) begin
                w = 0;
                for (int k = 1; k <= N; k++) begin
                    idx = (last + k) % N;
                    if (req[idx]) begin
                        w = idx;
                        break;
                    end
                end
                op  = req_op[w*OW +: OW];
                a   = req_a[w*DW +: DW];
                b   = req_b[w*DW +: DW];
                err = op > 3'd4;
                gq.push_back('{edge_n, w, err ? 3'd0 : op, a, b});
                rq.push_back('{edge_n + LAT + 1, w, err ? 8'h00 : alu_f(op, a, b), err});
                last    = w;
                g_edge  = edge_n;
                next_ok = edge_n + LAT + 2;
            end
        end
    end

    // Monitor
    initial begin
        gnt_t ge;
        rsp_t re;
        forever begin
            @(negedge clk);
            if (edge_n > 0) begin
                chk("enabled", enabled, !locked);
                chk("busy", busy, (edge_n - g_edge) <= LAT);
                if (gnt != '0 || (gq.size() > 0 && gq[0].edge_no == edge_n)) begin
                    for (int i = 0; i < N; i++) if (gnt[i]) begin
                        gnt_log.push_back(i);
                        gnt_edge_log.push_back(edge_n);
                    end
                    if (gq.size() == 0) begin
                        chk("gnt_spurious", gnt, 0);
                    end else begin
                        ge = gq.pop_front();
                        chk("gnt_onehot", gnt, 1 << ge.id);
                        chk("gnt_edge", edge_n, ge.edge_no);
                        chk("alu_opcode", alu_opcode, ge.op);
                        chk("alu_a", alu_a, ge.a);
                        chk("alu_b", alu_b, ge.b);
                    end
                end
                if (rsp_valid || (rq.size() > 0 && rq[0].edge_no == edge_n)) begin
                    if (rsp_valid) begin
                        n_rsp++;
                        last_id   = rsp_id;
                        last_data = rsp_data;
                        last_err  = rsp_err;
                    end
                    if (rq.size() == 0) begin
                        chk("rsp_spurious", rsp_valid, 0);
                    end else begin
                        re = rq.pop_front();
                        chk("rsp_valid", rsp_valid, 1);
                        chk("rsp_edge", edge_n, re.edge_no);
                        chk("rsp_id", rsp_id, re.id);
                        chk("rsp_data", rsp_data, re.data);
                        chk("rsp_err", rsp_err, re.err);
                    end
                end
            end
        end
    end

    // Requesters: drop req when own gnt is seen; optionally re-raise or raise at random.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    req[i]   = 1'b0;
                    rearm[i] = rr_mode;
                end else begin
                    if (rearm[i]) begin
                        req[i]   = 1'b1;
                        rearm[i] = 1'b0;
                    end else if (auto_en && !req[i] && $urandom_range(3) == 0) begin
                        req[i] = 1'b1;
                    end
                    if (auto_en) begin
                        req_op[i*OW +: OW] = 3'($urandom_range(7));
                        req_a[i*DW +: DW]  = 8'($urandom);
                        req_b[i*DW +: DW]  = 8'($urandom);
                    end
                end
            end
        end
    end

    task automatic set_ops(input int i, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b);
        req_op[i*OW +: OW] = op;
        req_a[i*DW +: DW]  = a;
        req_b[i*DW +: DW]  = b;
    endtask

    task automatic wait_gnt(input int i);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!gnt[i] && t < 50);
        chk("wait_gnt", gnt[i], 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((req != '0 || rearm != '0 || busy || rsp_valid) && t < 100);
        chk("wait_idle", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic issue(input int i, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        set_ops(i, op, a, b);
        req[i] = 1'b1;
        wait_gnt(i);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int base_rsp;
        int base_gnt;
        int t;
        rst = 1'b0; start_value = '0; req = '0; req_op = '0; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Locked: request ignored until the unlock word, then a single add
        set_ops(0, 3'd0, 8'h12, 8'h34);
        req[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("locked_no_gnt", gnt_log.size(), 0);
        start_value = CODE;
        @(negedge clk);
        start_value = '0;
        chk("unlock_enabled", enabled, 1);
        @(negedge clk);
        chk("unlock_gnt", gnt, 4'b0001);
        repeat (4) @(negedge clk);
        chk("add_count", n_rsp, 1);
        chk("add_id", last_id, 0);
        chk("add_data", last_data, 8'h46);
        chk("add_err", last_err, 0);

        // Round robin with all four requesting
        gnt_log.delete();
        gnt_edge_log.delete();
        for (int i = 0; i < N; i++) set_ops(i, 3'(i), 8'(i * 17 + 3), 8'(i * 5 + 1));
        rr_mode = 1'b1;
        req = 4'b1111;
        repeat (18) @(negedge clk);
        rr_mode = 1'b0;
        chk("rr_count", gnt_log.size() >= 5, 1);
        if (gnt_log.size() >= 5) begin
            chk("rr_first", gnt_log[0], 1);
            for (int k = 0; k < 4; k++) begin
                chk("rr_order", gnt_log[k+1], (gnt_log[k] + 1) % N);
                chk("rr_spacing", gnt_edge_log[k+1] - gnt_edge_log[k], LAT + 2);
            end
        end
        wait_idle();

        // Illegal opcode
        issue(2, 3'd6, 8'h5A, 8'hA5);
        chk("illegal_id", last_id, 2);
        chk("illegal_err", last_err, 1);
        chk("illegal_data", last_data, 8'h00);
        chk("illegal_aluop", alu_opcode, 3'd0);

        // Subtract wrap, then back-to-back grant on the response cycle
        set_ops(1, 3'd1, 8'h10, 8'h20);
        set_ops(3, 3'd4, 8'h0F, 8'h00);
        req[1] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rsp_valid && t < 20);
        chk("wrap_valid", rsp_valid, 1);
        chk("wrap_data", rsp_data, 8'hF0);
        req[3] = 1'b1;
        @(negedge clk);
        chk("b2b_gnt", gnt, 4'b1000);
        wait_idle();

        // Random traffic with operand churn
        auto_en = 1'b1;
        repeat (400) @(negedge clk);
        auto_en = 1'b0;
        wait_idle();

        // Reset while in WAIT: op is dropped, block relocks
        set_ops(0, 3'd3, 8'h81, 8'h18);
        req[0] = 1'b1;
        wait_gnt(0);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        base_rsp = n_rsp;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_enabled", enabled, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", rsp_valid, 0);
        base_gnt = gnt_log.size();
        req[0] = 1'b1;
        repeat (10) @(negedge clk);
        chk("relock_no_rsp", n_rsp, base_rsp);
        chk("relock_no_gnt", gnt_log.size(), base_gnt);
        start_value = CODE;
        @(negedge clk);
        start_value = '0;
        repeat (6) @(negedge clk);
        chk("reunlock_rsp", n_rsp, base_rsp + 1);
        chk("reunlock_data", last_data, 8'h99);

        wait_idle();
        chk("gq_empty", gq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
